// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, functional-unit indices and write-back bundle
package core_pkg;
  localparam int XLEN    = 32;
  localparam int REGW    = 5;
  localparam int NUM_FU  = 5;
  localparam int FU_IDXW = $clog2(NUM_FU);

  localparam int FU_ALU  = 0;
  localparam int FU_JUMP = 1;
  localparam int FU_MEM  = 2;
  localparam int FU_MUL  = 3;
  localparam int FU_DIV  = 4;

  typedef struct packed {
    logic               valid;
    logic [REGW-1:0]    rd;
    logic [XLEN-1:0]    data;
    logic [FU_IDXW-1:0] fu;
  } wb_bundle_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - request vector to one-hot grant; rotating pointer when FU_WB_RR_EN is defined
module wb_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

`ifdef FU_WB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [N-1:0]  above;

  // requests at or above the pointer win; otherwise wrap to the lowest request
  always_comb begin
    above = req & ~((N'(1) << ptr_q) - N'(1));
    grant = (|above) ? (above & (-above)) : (req & (-req));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (|req) begin
      ptr_q <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign grant = req & (-req);
`endif

endmodule

// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - per-FU result slots arbitrated onto one write-back port (FU_WB_RR_EN selects round-robin)
module fu_wb_arbiter #(
  parameter int NUM_FU = core_pkg::NUM_FU,
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REGW   = core_pkg::REGW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_FU-1:0]          fu_finish,
  input  logic [NUM_FU*XLEN-1:0]     fu_res,
  input  logic [NUM_FU*REGW-1:0]     fu_rd,
  output logic [NUM_FU-1:0]          fu_hold,
  output logic                       wb_valid,
  output logic                       wb_we,
  output logic [REGW-1:0]            wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic [$clog2(NUM_FU)-1:0]  wb_fu,
  output logic                       ovf
);

  localparam int FW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]    full_q;
  logic [NUM_FU-1:0]    grant;
  logic [FW-1:0]        grant_idx;
  logic [XLEN-1:0]      data_q [NUM_FU];
  logic [REGW-1:0]      rd_q   [NUM_FU];
  core_pkg::wb_bundle_t wb_q;
  logic                 ovf_q;

  wb_rr_arbiter #(.N(NUM_FU)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (full_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // payload needs no reset: it is only observed while its full bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_finish[i]) begin
        data_q[i] <= fu_res[i*XLEN +: XLEN];
        rd_q[i]   <= fu_rd[i*REGW +: REGW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      ovf_q  <= 1'b0;
      wb_q   <= '0;
    end else begin
      // a finish on the granted slot refills it while the old payload leaves this edge
      full_q   <= fu_finish | (full_q & ~grant);
      if (|(fu_finish & full_q & ~grant)) ovf_q <= 1'b1;
      wb_q.valid <= |grant;
      if (|grant) begin
        wb_q.rd   <= rd_q[grant_idx];
        wb_q.data <= data_q[grant_idx];
        wb_q.fu   <= grant_idx;
      end
    end
  end

  assign fu_hold  = full_q & ~grant;
  assign wb_valid = wb_q.valid;
  assign wb_we    = wb_q.valid & (wb_q.rd != '0);
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign wb_fu    = wb_q.fu;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb/tb_fu_wb_arbiter.sv - testbench for fu_wb_arbiter (honours FU_WB_RR_EN)
module tb_fu_wb_arbiter;
  import core_pkg::*;

  localparam int N = NUM_FU;
`ifdef FU_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         fu_finish;
  logic [N*XLEN-1:0]    fu_res;
  logic [N*REGW-1:0]    fu_rd;
  logic [N-1:0]         fu_hold;
  logic                 wb_valid, wb_we, ovf;
  logic [REGW-1:0]      wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [FU_IDXW-1:0]   wb_fu;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fu_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .fu_finish(fu_finish), .fu_res(fu_res), .fu_rd(fu_rd),
    .fu_hold(fu_hold), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_fu(wb_fu), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: one slot per FU, policy applied directly from the rules
  bit              m_full [N];
  logic [XLEN-1:0] m_data [N];
  logic [REGW-1:0] m_rd   [N];
  int              m_ptr;
  bit              m_ovf;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    m_ptr = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i = RR ? (m_ptr + k) % N : k;
      if (m_full[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_cycle(input logic [N-1:0] fin, input logic [N*XLEN-1:0] res,
                           input logic [N*REGW-1:0] rd);
    int g, efu;
    bit ev;
    logic [N-1:0] ehold;
    logic [REGW-1:0] erd;
    logic [XLEN-1:0] edata;
    fu_finish = fin; fu_res = res; fu_rd = rd;
    g = pick();
    ehold = '0;
    for (int i = 0; i < N; i++) if (m_full[i] && i != g) ehold[i] = 1'b1;
    #1 chk("model hold", fu_hold, ehold);
    ev = (g >= 0); erd = '0; edata = '0; efu = 0;
    if (ev) begin
      erd = m_rd[g]; edata = m_data[g]; efu = g;
      m_full[g] = 1'b0;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (fin[i]) begin
        if (m_full[i]) m_ovf = 1'b1;
        m_full[i] = 1'b1;
        m_data[i] = res[i*XLEN +: XLEN];
        m_rd[i]   = rd[i*REGW +: REGW];
      end
    end
    @(posedge clk); @(negedge clk);
    chk("model wb_valid", wb_valid, ev);
    chk("model wb_we", wb_we, ev && erd != 0);
    chk("model ovf", ovf, m_ovf);
    if (ev) begin
      chk("model wb_rd", wb_rd, erd);
      chk("model wb_data", wb_data, edata);
      chk("model wb_fu", wb_fu, efu);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] fin);
    @(negedge clk);
    rst_n = 1'b0; fu_finish = fin; fu_res = '1; fu_rd = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; fu_finish = '0;
    model_reset();
  endtask

  function automatic logic [N*XLEN-1:0] rand_res();
    logic [N*XLEN-1:0] r;
    for (int i = 0; i < N; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  function automatic logic [N*REGW-1:0] rand_rd();
    logic [N*REGW-1:0] r;
    for (int i = 0; i < N; i++) r[i*REGW +: REGW] = REGW'($urandom);
    return r;
  endfunction

  typedef struct {
    logic [N-1:0]    fin;
    logic [XLEN-1:0] rbase;
    logic [REGW-1:0] dbase;
    logic [N-1:0]    hold;
    logic            v;
    int              fu;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
    logic            ovf;
  } row_t;

  row_t tbl [22];

  function automatic row_t mk(logic [N-1:0] fin, logic [XLEN-1:0] rb, logic [REGW-1:0] db,
                              logic [N-1:0] hold, logic v, int fu, logic [REGW-1:0] rd,
                              logic [XLEN-1:0] data, logic o);
    row_t r;
    r.fin = fin; r.rbase = rb; r.dbase = db; r.hold = hold; r.v = v;
    r.fu = fu; r.rd = rd; r.data = data; r.ovf = o;
    return r;
  endfunction

  task automatic apply_row(input row_t r, input int idx);
    for (int i = 0; i < N; i++) begin
      fu_res[i*XLEN +: XLEN] = r.rbase + XLEN'(i);
      fu_rd[i*REGW +: REGW]  = r.dbase + REGW'(i);
    end
    fu_finish = r.fin;
    #1 chk($sformatf("row%0d hold", idx), fu_hold, r.hold);
    @(posedge clk); @(negedge clk);
    chk($sformatf("row%0d wb_valid", idx), wb_valid, r.v);
    chk($sformatf("row%0d wb_we", idx), wb_we, r.v && r.rd != 0);
    chk($sformatf("row%0d ovf", idx), ovf, r.ovf);
    if (r.v) begin
      chk($sformatf("row%0d wb_fu", idx), wb_fu, r.fu);
      chk($sformatf("row%0d wb_rd", idx), wb_rd, r.rd);
      chk($sformatf("row%0d wb_data", idx), wb_data, r.data);
    end
  endtask

  initial begin
    int first4;
    rst_n = 1'b0; fu_finish = '1; fu_res = '0; fu_rd = '0;

    tbl[0]  = mk(5'b10000, 32'h3, 5'd1, 5'b00000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(5'b00000, 0, 0, 5'b00000, 1, FU_DIV, 5, 32'h7, 0);
    tbl[2]  = mk(5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
    tbl[3]  = mk(5'b11111, 32'h10, 5'd1, 5'b00000, 0, 0, 0, 0, 0);
    tbl[4]  = mk(5'b00000, 0, 0, 5'b11110, 1, FU_ALU, 1, 32'h10, 0);
    tbl[5]  = mk(5'b00000, 0, 0, 5'b11100, 1, FU_JUMP, 2, 32'h11, 0);
    tbl[6]  = mk(5'b00000, 0, 0, 5'b11000, 1, FU_MEM, 3, 32'h12, 0);
    tbl[7]  = mk(5'b00000, 0, 0, 5'b10000, 1, FU_MUL, 4, 32'h13, 0);
    tbl[8]  = mk(5'b00000, 0, 0, 5'b00000, 1, FU_DIV, 5, 32'h14, 0);
    tbl[9]  = mk(5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
    tbl[10] = mk(5'b00011, 32'h20, 5'd1, 5'b00000, 0, 0, 0, 0, 0);
    tbl[11] = mk(5'b00001, 32'h30, 5'd6, 5'b00010, 1, 0, 1, 32'h20, 0);
`ifdef FU_WB_RR_EN
    tbl[12] = mk(5'b00000, 0, 0, 5'b00001, 1, 1, 2, 32'h21, 0);
    tbl[13] = mk(5'b00000, 0, 0, 5'b00000, 1, 0, 6, 32'h30, 0);
`else
    tbl[12] = mk(5'b00000, 0, 0, 5'b00010, 1, 0, 6, 32'h30, 0);
    tbl[13] = mk(5'b00000, 0, 0, 5'b00000, 1, 1, 2, 32'h21, 0);
`endif
    tbl[14] = mk(5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
    tbl[15] = mk(5'b01100, 32'h40, 5'd8, 5'b00000, 0, 0, 0, 0, 0);
    tbl[16] = mk(5'b01000, 32'h50, 5'd8, 5'b01000, 1, 2, 10, 32'h42, 1);
    tbl[17] = mk(5'b00000, 0, 0, 5'b00000, 1, 3, 11, 32'h53, 1);
    tbl[18] = mk(5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 1);
    tbl[19] = mk(5'b00100, 32'hFFFF_FFFD, 5'd30, 5'b00000, 0, 0, 0, 0, 1);
    tbl[20] = mk(5'b00000, 0, 0, 5'b00000, 1, 2, 0, 32'hFFFF_FFFF, 1);
    tbl[21] = mk(5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 1);

    do_reset('1);
    #1;
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_we", wb_we, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_fu", wb_fu, 0);
    chk("rst ovf", ovf, 0);
    chk("rst fu_hold", fu_hold, 0);
    repeat (3) run_cycle('0, '0, '0);

    for (int k = 0; k < 22; k++) apply_row(tbl[k], k);

    do_reset('0);
    first4 = -1;
    for (int c = 0; c < 14; c++) begin
      logic [N-1:0] fin;
      fin = (c == 0) ? 5'b10001 : (c < 10) ? 5'b00001 : 5'b00000;
      run_cycle(fin, rand_res(), rand_rd());
      if (first4 < 0 && wb_valid && wb_fu == FU_IDXW'(FU_DIV)) first4 = c;
    end
    chk("fu4 first write cycle", first4, RR ? 2 : 11);

    for (int c = 0; c < 400; c++)
      run_cycle(N'($urandom) & N'($urandom), rand_res(), rand_rd());

    run_cycle('1, rand_res(), rand_rd());
    run_cycle(5'b10101, rand_res(), rand_rd());
    do_reset('1);
    repeat (3) run_cycle('0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
